// File: rtl/lite16_pkg.sv
// Shared definitions for the LITE-16 register fetch slice: flag positions,
// immediate placement and the register-index width helper.
package lite16_pkg;

  // Bit positions of the instruction class flags inside the decode flag vector
  localparam int FLAG_RI  = 0;
  localparam int FLAG_ST  = 1;
  localparam int FLAG_JMP = 2;
  localparam int FLAG_FN  = 3;
  localparam int FLAG_W   = 4;

  // The ri-form B immediate sits this many bits above the LSB
  localparam int IMM_B_SHIFT = 4;

  // Width of a register index for a bank of n registers (at least one bit)
  function automatic int reg_idx_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/register_fetch_stage_if.sv
// Decode-side, write-back and execute-side signals of the register fetch stage.
interface register_fetch_stage_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [AW-1:0]     fld_a;
  logic [AW-1:0]     fld_b;
  logic [AW-1:0]     fld_d;
  logic              ri;
  logic              st;
  logic              jmp;
  logic              fn;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] s2;
  logic [DATA_W-1:0] rd;
  logic              out_wen;
  logic [AW-1:0]     out_wdest;

  modport master (
    output in_valid, fld_a, fld_b, fld_d, ri, st, jmp, fn,
    output wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, a, b, s2, rd, out_wen, out_wdest
  );

  modport slave (
    input  in_valid, fld_a, fld_b, fld_d, ri, st, jmp, fn,
    input  wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, a, b, s2, rd, out_wen, out_wdest
  );
endinterface

// File: rtl/lite16_regfile.sv
// Register bank: one synchronous write port, three asynchronous read ports.
// With ZERO_R0 set, writes to r0 are dropped so r0 stays at its reset value 0.
module lite16_regfile
  import lite16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ZERO_R0  = 0,
  localparam int AW      = reg_idx_w(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] bank_r [NUM_REGS];
  logic              write_ok_s;

  assign write_ok_s = we && !((ZERO_R0 != 0) && (waddr == {AW{1'b0}}));

  // Clear the whole bank on reset, otherwise commit the write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_r[i] <= {DATA_W{1'b0}};
      end
    end else if (write_ok_s) begin
      bank_r[waddr] <= wdata;
    end
  end

  assign rdata0 = bank_r[raddr0];
  assign rdata1 = bank_r[raddr1];
  assign rdata2 = bank_r[raddr2];
endmodule

// File: rtl/register_fetch_stage.sv
// Register fetch stage: decodes source/destination fields, reads operands with
// write-back bypass, tracks in-flight destinations in a pending scoreboard and
// presents operands through a one-entry valid/ready output register.
module register_fetch_stage
  import lite16_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ZERO_R0  = 0
) (
  input logic                   clk,
  input logic                   rst,
  register_fetch_stage_if.slave bus
);
  localparam int AW = reg_idx_w(NUM_REGS);

  logic [FLAG_W-1:0]   flags_s;
  logic                ri_s, use_a_s, use_d_s, wen_s;
  logic [AW-1:0]       wdest_s;
  logic [DATA_W-1:0]   rf_a_s, rf_b_s, rf_d_s;
  logic [DATA_W-1:0]   val_a_s, val_b_s, val_d_s;
  logic [DATA_W-1:0]   next_a_s, next_b_s;
  logic [NUM_REGS-1:0] pending_r, busy_s, pending_nxt_s;
  logic                stall_s, accept_s, kill_s, set_s;
  logic                out_valid_r, out_wen_r;
  logic [AW-1:0]       out_wdest_r;
  logic [DATA_W-1:0]   a_r, b_r, s2_r, rd_r;

  // Register read with same-cycle write-back forwarding; r0 is hard zero when enabled
  function automatic logic [DATA_W-1:0] read_port(
    input logic [AW-1:0]     x,
    input logic [DATA_W-1:0] bank_v,
    input logic              we,
    input logic [AW-1:0]     wa,
    input logic [DATA_W-1:0] wd
  );
    logic [DATA_W-1:0] v;
    if ((ZERO_R0 != 0) && (x == {AW{1'b0}})) begin
      v = {DATA_W{1'b0}};
    end else if (we && (wa == x)) begin
      v = wd;
    end else begin
      v = bank_v;
    end
    return v;
  endfunction

  lite16_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_R0  (ZERO_R0)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.wb_en),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr0 (bus.fld_a),
    .raddr1 (bus.fld_b),
    .raddr2 (bus.fld_d),
    .rdata0 (rf_a_s),
    .rdata1 (rf_b_s),
    .rdata2 (rf_d_s)
  );

  // Decode class flags into source usage, write enable and destination
  always_comb begin
    flags_s          = {FLAG_W{1'b0}};
    flags_s[FLAG_RI]  = bus.ri;
    flags_s[FLAG_ST]  = bus.st;
    flags_s[FLAG_JMP] = bus.jmp;
    flags_s[FLAG_FN]  = bus.fn;
    ri_s    = flags_s[FLAG_RI];
    use_a_s = !flags_s[FLAG_RI];
    use_d_s = flags_s[FLAG_ST] | flags_s[FLAG_JMP];
    wen_s   = !(flags_s[FLAG_ST] | (flags_s[FLAG_JMP] & !flags_s[FLAG_FN]));
    wdest_s = flags_s[FLAG_FN] ? bus.fld_b : bus.fld_d;
  end

  // Operand values: bypassed register reads, immediates for ri-form
  always_comb begin
    val_a_s  = read_port(bus.fld_a, rf_a_s, bus.wb_en, bus.wb_addr, bus.wb_data);
    val_b_s  = read_port(bus.fld_b, rf_b_s, bus.wb_en, bus.wb_addr, bus.wb_data);
    val_d_s  = read_port(bus.fld_d, rf_d_s, bus.wb_en, bus.wb_addr, bus.wb_data);
    next_a_s = ri_s ? DATA_W'(bus.fld_a) : val_a_s;
    next_b_s = ri_s ? DATA_W'({bus.fld_b, {IMM_B_SHIFT{1'b0}}}) : val_b_s;
  end

  // Hazard detection and scoreboard next state; a write-back this cycle retires its register
  always_comb begin
    busy_s              = pending_r;
    busy_s[bus.wb_addr] = pending_r[bus.wb_addr] & ~bus.wb_en;
    stall_s  = (use_a_s & busy_s[bus.fld_a]) | busy_s[bus.fld_b] |
               (use_d_s & busy_s[bus.fld_d]) | (wen_s & busy_s[wdest_s]);
    accept_s = bus.in_valid & !rst & !bus.flush & !stall_s & (!out_valid_r | bus.out_ready);
    kill_s   = bus.flush & out_valid_r & out_wen_r;
    set_s    = accept_s & wen_s & !((ZERO_R0 != 0) && (wdest_s == {AW{1'b0}}));
    pending_nxt_s              = busy_s;
    pending_nxt_s[out_wdest_r] = pending_nxt_s[out_wdest_r] & ~kill_s;
    pending_nxt_s[wdest_s]     = pending_nxt_s[wdest_s] | set_s;
  end

  assign bus.in_ready = !rst && !bus.flush && !stall_s && (!out_valid_r || bus.out_ready);

  // Pending-write scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // One-entry output register: load on accept, drop on flush or consume
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_wen_r   <= 1'b0;
      out_wdest_r <= {AW{1'b0}};
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      s2_r        <= {DATA_W{1'b0}};
      rd_r        <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_wen_r   <= wen_s;
      out_wdest_r <= wdest_s;
      a_r         <= next_a_s;
      b_r         <= next_b_s;
      s2_r        <= val_b_s;
      rd_r        <= val_d_s;
    end else if (bus.flush || bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_wen   = out_wen_r;
  assign bus.out_wdest = out_wdest_r;
  assign bus.a         = a_r;
  assign bus.b         = b_r;
  assign bus.s2        = s2_r;
  assign bus.rd        = rd_r;
endmodule
